// File: rtl/tank_pkg.sv
// Shared tank-game definitions: direction codes, map limits, bullet FSM encoding
// and the one-cell step helper used for both launch and flight.
package tank_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [4:0] MAP_X_MAX = 5'd15;
  localparam logic [4:0] MAP_Y_MAX = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_COOL = 2'd2
  } bul_fsm_e;

  typedef struct packed {
    logic       ok;
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  // Neighbouring cell in direction dir; one spare bit turns underflow/overflow into "off-map".
  function automatic cell_t next_cell(input logic [4:0] x, input logic [4:0] y,
                                      input logic [1:0] dir,
                                      input logic [4:0] x_max, input logic [4:0] y_max);
    logic [5:0] nx;
    logic [5:0] ny;
    cell_t      c;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (dir)
      DIR_UP:   ny = ny - 6'd1;
      DIR_LEFT: nx = nx - 6'd1;
      DIR_DOWN: ny = ny + 6'd1;
      default:  nx = nx + 6'd1;
    endcase
    c.ok = (nx <= {1'b0, x_max}) && (ny <= {1'b0, y_max});
    c.x  = nx[4:0];
    c.y  = ny[4:0];
    return c;
  endfunction

endpackage

// File: rtl/mybullet_app_if.sv
// Bullet-side bundle: tank/enemy inputs towards the bullet, bullet position and hits back.
interface mybullet_app_if;
  logic       bul_en;
  logic       bul_sht;
  logic [1:0] tank_dir;
  logic [4:0] tank_x;
  logic [4:0] tank_y;
  logic [4:0] enemy1_x;
  logic [4:0] enemy1_y;
  logic [4:0] enemy2_x;
  logic [4:0] enemy2_y;
  logic [4:0] bul_x;
  logic [4:0] bul_y;
  logic       bul_state;
  logic [1:0] bul_dir;
  logic       hit1;
  logic       hit2;

  modport master (
    output bul_en, bul_sht, tank_dir, tank_x, tank_y,
           enemy1_x, enemy1_y, enemy2_x, enemy2_y,
    input  bul_x, bul_y, bul_state, bul_dir, hit1, hit2
  );

  modport slave (
    input  bul_en, bul_sht, tank_dir, tank_x, tank_y,
           enemy1_x, enemy1_y, enemy2_x, enemy2_y,
    output bul_x, bul_y, bul_state, bul_dir, hit1, hit2
  );
endinterface

// File: rtl/slow_tick_gen.sv
// Two-flop synchronizer plus rising-edge detect: turns the slow game clock into a 1-cycle tick.
module slow_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic clk_slow,
  output logic tick
);
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], clk_slow};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign tick = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/mybullet_app.sv
// Player bullet: launches from the cell the tank faces, steps every MOVE_DIV slow ticks and
// retires on a map edge or enemy hit. Define MYBULLET_COOLDOWN_EN for a post-retire cooldown.
module mybullet_app
  import tank_pkg::*;
#(
  parameter logic [4:0] X_MAX    = MAP_X_MAX,
  parameter logic [4:0] Y_MAX    = MAP_Y_MAX,
  parameter int         MOVE_DIV = 2,
  parameter int         COOLDOWN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_4Hz,
  mybullet_app_if.slave bus
);
  // One counter paces both moves and cooldown, so it is sized for the larger of the two.
  localparam int               CNT_MAX   = (MOVE_DIV > COOLDOWN) ? MOVE_DIV : COOLDOWN;
  localparam int               CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_DIV - 1);
`ifdef MYBULLET_COOLDOWN_EN
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
  localparam bul_fsm_e         RETIRE_ST = ST_COOL;
`else
  localparam bul_fsm_e         RETIRE_ST = ST_IDLE;
`endif

  logic             tick;
  logic             fire;
  logic             retire;
  cell_t            launch_cell;
  cell_t            flight_cell;
  bul_fsm_e         state_q,     state_d;
  logic [4:0]       bul_x_q,     bul_x_d;
  logic [4:0]       bul_y_q,     bul_y_d;
  logic [1:0]       bul_dir_q,   bul_dir_d;
  logic             bul_state_q, bul_state_d;
  logic             hit1_q,      hit1_d;
  logic             hit2_q,      hit2_d;
  logic             sht_prev_q,  sht_prev_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  slow_tick_gen u_tick (
    .clk      (clk),
    .rst      (rst),
    .clk_slow (clk_4Hz),
    .tick     (tick)
  );

  assign fire        = bus.bul_sht & ~sht_prev_q;
  assign launch_cell = next_cell(bus.tank_x, bus.tank_y, bus.tank_dir, X_MAX, Y_MAX);
  assign flight_cell = next_cell(bul_x_q, bul_y_q, bul_dir_q, X_MAX, Y_MAX);

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the block can infer a latch.
    state_d     = state_q;
    bul_x_d     = bul_x_q;
    bul_y_d     = bul_y_q;
    bul_dir_d   = bul_dir_q;
    bul_state_d = bul_state_q;
    cnt_d       = cnt_q;
    hit1_d      = 1'b0;
    hit2_d      = 1'b0;
    retire      = 1'b0;
    sht_prev_d  = bus.bul_sht;

    if (!bus.bul_en) begin
      state_d     = ST_IDLE;
      bul_state_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fire && launch_cell.ok) begin
            state_d     = ST_FLY;
            bul_x_d     = launch_cell.x;
            bul_y_d     = launch_cell.y;
            bul_dir_d   = bus.tank_dir;
            bul_state_d = 1'b1;
            cnt_d       = '0;
          end
        end
        ST_FLY: begin
          // Hit has priority over a move in the same cycle; enemy 1 wins a shared cell.
          if (bul_x_q == bus.enemy1_x && bul_y_q == bus.enemy1_y) begin
            hit1_d = 1'b1;
            retire = 1'b1;
          end else if (bul_x_q == bus.enemy2_x && bul_y_q == bus.enemy2_y) begin
            hit2_d = 1'b1;
            retire = 1'b1;
          end else if (tick) begin
            if (cnt_q == MOVE_LAST) begin
              cnt_d = '0;
              if (flight_cell.ok) begin
                bul_x_d = flight_cell.x;
                bul_y_d = flight_cell.y;
              end else begin
                retire = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef MYBULLET_COOLDOWN_EN
        ST_COOL: begin
          if (tick) begin
            if (cnt_q == COOL_LAST) state_d = ST_IDLE;
            else                    cnt_d   = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase

      if (retire) begin
        state_d     = RETIRE_ST;
        bul_state_d = 1'b0;
        cnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bul_x_q     <= '0;
      bul_y_q     <= '0;
      bul_dir_q   <= '0;
      bul_state_q <= 1'b0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      sht_prev_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bul_x_q     <= bul_x_d;
      bul_y_q     <= bul_y_d;
      bul_dir_q   <= bul_dir_d;
      bul_state_q <= bul_state_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      sht_prev_q  <= sht_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bul_x     = bul_x_q;
  assign bus.bul_y     = bul_y_q;
  assign bus.bul_dir   = bul_dir_q;
  assign bus.bul_state = bul_state_q;
  assign bus.hit1      = hit1_q;
  assign bus.hit2      = hit2_q;
endmodule

// File: tb/tb_mybullet_app.sv
// Scoreboard bench for mybullet_app: a cycle-level game model queues every expected output
// change; a negedge monitor pops one entry per observed DUT output change and compares.
module tb_mybullet_app;
  localparam int MOVE_DIV = 2;
  localparam int COOLDOWN = 3;
  localparam int XM       = 15;
  localparam int YM       = 11;
  localparam int M_IDLE   = 0;
  localparam int M_FLY    = 1;
  localparam int M_COOL   = 2;
`ifdef MYBULLET_COOLDOWN_EN
  localparam bit COOL_EN = 1'b1;
`else
  localparam bit COOL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic       st;
    logic [1:0] dir;
    logic       h1;
    logic       h2;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic clk_4hz = 1'b0;

  mybullet_app_if bus ();

  mybullet_app #(
    .X_MAX    (5'd15),
    .Y_MAX    (5'd11),
    .MOVE_DIV (MOVE_DIV),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_4Hz (clk_4hz),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs_now();
    return {bus.bul_x, bus.bul_y, bus.bul_state, bus.bul_dir, bus.hit1, bus.hit2};
  endfunction

  function automatic bit on_map(input int x, input int y);
    return x >= 0 && x <= XM && y >= 0 && y <= YM;
  endfunction

  // ---------------- reference model: game rules on plain integers ----------------
  int   dx[4] = '{0, -1, 0, 1};
  int   dy[4] = '{-1, 0, 1, 0};
  int   m_cyc = 0;
  int   m_mode = M_IDLE;
  int   m_x = 0, m_y = 0, m_dir = 0, m_cnt = 0;
  bit   m_st = 0, m_h1 = 0, m_h2 = 0;
  bit   m_s1 = 0, m_s2 = 0, m_s3 = 0, m_prev = 0;
  obs_t m_last = '0;

  function automatic void m_retire();
    m_st   = 1'b0;
    m_cnt  = 0;
    m_mode = COOL_EN ? M_COOL : M_IDLE;
  endfunction

  always @(posedge clk) begin
    bit   tk;
    bit   fr;
    int   nx;
    int   ny;
    obs_t cur;
    m_cyc++;
    // slow clock seen through two sync stages: a rise is acted on three edges later
    tk     = m_s2 && !m_s3;
    fr     = bus.bul_sht && !m_prev;
    m_s3   = m_s2;
    m_s2   = m_s1;
    m_s1   = clk_4hz;
    m_prev = bus.bul_sht;
    m_h1   = 1'b0;
    m_h2   = 1'b0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_prev = 0;
      m_mode = M_IDLE; m_st = 0; m_x = 0; m_y = 0; m_dir = 0; m_cnt = 0;
    end else if (!bus.bul_en) begin
      m_mode = M_IDLE;
      m_st   = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (fr) begin
        nx = int'(bus.tank_x) + dx[bus.tank_dir];
        ny = int'(bus.tank_y) + dy[bus.tank_dir];
        if (on_map(nx, ny)) begin
          m_x = nx; m_y = ny; m_dir = int'(bus.tank_dir);
          m_st = 1'b1; m_mode = M_FLY; m_cnt = 0;
        end
      end
    end else if (m_mode == M_FLY) begin
      if (m_x == int'(bus.enemy1_x) && m_y == int'(bus.enemy1_y)) begin
        m_h1 = 1'b1;
        m_retire();
      end else if (m_x == int'(bus.enemy2_x) && m_y == int'(bus.enemy2_y)) begin
        m_h2 = 1'b1;
        m_retire();
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == MOVE_DIV) begin
          m_cnt = 0;
          nx = m_x + dx[m_dir];
          ny = m_y + dy[m_dir];
          if (on_map(nx, ny)) begin
            m_x = nx;
            m_y = ny;
          end else begin
            m_retire();
          end
        end
      end
    end else begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == COOLDOWN) m_mode = M_IDLE;
      end
    end
    cur = '{x: 5'(m_x), y: 5'(m_y), st: m_st, dir: 2'(m_dir), h1: m_h1, h2: m_h2};
    if (cur != m_last) exp_q.push_back('{m_cyc, cur});
    m_last = cur;
  end

  // ---------------- monitor ----------------
  bit   mon_en   = 1'b0;
  obs_t last_obs = '0;

  always @(negedge clk) begin
    obs_t now;
    exp_t e;
    if (mon_en) begin
      now = obs_now();
      if (now !== last_obs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got 0x%0h at cycle %0d, expected no change",
                   now, m_cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", m_cyc, e.cyc);
          check("event_value", 32'(now), 32'(e.o));
        end
        last_obs = now;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    forever begin
      int h;
      h = $urandom_range(2, 5);
      repeat (h) @(posedge clk);
      #1 clk_4hz = ~clk_4hz;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic place(input int tx, input int ty, input int d,
                       input int e1x, input int e1y, input int e2x, input int e2y);
    bus.tank_x   = 5'(tx);
    bus.tank_y   = 5'(ty);
    bus.tank_dir = 2'(d);
    bus.enemy1_x = 5'(e1x);
    bus.enemy1_y = 5'(e1y);
    bus.enemy2_x = 5'(e2x);
    bus.enemy2_y = 5'(e2y);
  endtask

  task automatic shoot();
    bus.bul_sht = 1'b1;
    cyc(1);
    bus.bul_sht = 1'b0;
    cyc(1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (m_mode != M_IDLE && n < budget) begin
      cyc(1);
      n++;
    end
    if (m_mode != M_IDLE) begin
      checks++;
      errors++;
      $display("FAIL timeout: bullet still active after %0d cycles", budget);
    end
  endtask

  task automatic wait_retire(input int budget);
    int n = 0;
    while (m_st && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    bus.bul_en  = 1'b0;
    bus.bul_sht = 1'b0;
    place(0, 0, 0, 31, 31, 31, 31);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(obs_now()), 32'd0);
    last_obs   = '0;
    mon_en     = 1'b1;
    bus.bul_en = 1'b1;
    cyc(2);

    // launch up, then turn the tank: the bullet keeps its latched direction
    place(5, 5, 0, 31, 31, 31, 31);
    shoot();
    bus.tank_dir = 2'd3;
    wait_done(1000);

    // right edge retire from (15,2)
    place(14, 2, 3, 31, 31, 31, 31);
    shoot();
    wait_done(1000);

    // enemy hits: enemy1 alone, both on one cell, enemy2 alone, enemy on launch cell
    place(2, 6, 3, 5, 6, 31, 31);
    shoot();
    wait_done(1000);
    place(2, 6, 3, 5, 6, 5, 6);
    shoot();
    wait_done(1000);
    place(2, 6, 3, 31, 31, 5, 6);
    shoot();
    wait_done(1000);
    place(7, 7, 1, 6, 7, 31, 31);
    shoot();
    wait_done(1000);

    // off-map launches are dropped
    place(0, 0, 0, 31, 31, 31, 31);
    shoot();
    place(15, 3, 3, 31, 31, 31, 31);
    shoot();
    place(4, 11, 2, 31, 31, 31, 31);
    shoot();
    place(0, 4, 1, 31, 31, 31, 31);
    shoot();
    cyc(4);

    // second fire while flying is ignored
    place(8, 8, 0, 31, 31, 31, 31);
    shoot();
    cyc(7);
    place(3, 3, 2, 31, 31, 31, 31);
    shoot();
    wait_done(1000);

    // disable mid-flight, with a fire edge while disabled
    place(1, 1, 2, 31, 31, 31, 31);
    shoot();
    cyc(15);
    bus.bul_en  = 1'b0;
    bus.bul_sht = 1'b1;
    cyc(1);
    bus.bul_sht = 1'b0;
    cyc(3);
    bus.bul_en = 1'b1;
    cyc(3);

    // reset mid-flight
    place(10, 10, 1, 31, 31, 31, 31);
    shoot();
    cyc(12);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);

    // fire on the cycle right after a retire
    place(14, 5, 3, 31, 31, 31, 31);
    shoot();
    wait_retire(1000);
    place(6, 6, 2, 31, 31, 31, 31);
    bus.bul_sht = 1'b1;
    cyc(1);
    bus.bul_sht = 1'b0;
    cyc(1);
    wait_done(1000);
    place(6, 6, 2, 31, 31, 31, 31);
    shoot();
    wait_done(1000);

    // randomized shots, enemies often placed on the flight line
    for (int i = 0; i < 40; i++) begin
      int tx, ty, d, ex, ey;
      tx = $urandom_range(0, XM);
      ty = $urandom_range(0, YM);
      d  = $urandom_range(0, 3);
      ex = $urandom_range(0, XM);
      ey = $urandom_range(0, YM);
      if ($urandom_range(0, 1) == 1) begin
        if (d[0]) ey = ty;
        else      ex = tx;
      end
      place(tx, ty, d, ex, ey, $urandom_range(0, XM), $urandom_range(0, YM));
      shoot();
      bus.tank_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        cyc($urandom_range(1, 30));
        bus.bul_en = 1'b0;
        cyc($urandom_range(1, 4));
        bus.bul_en = 1'b1;
      end
      wait_done(1000);
    end

    cyc(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
